// File: rtl/mode_select.sv
// rtl/mode_select.sv - push-button to animation mode selector (sync, debounce, short/long press)
module mode_select #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int NUM_MODES         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic       btn_level
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [1:0]        MODE_LAST = 2'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  logic              s1;
  logic              s2;
  logic [DB_W-1:0]   db_cnt;
  logic              btn_prev;
  state_t            state;
  state_t            state_n;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_n;
  logic [1:0]        mode_n;
  logic              changed_n;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (s2 == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_level <= s2;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press FSM state, hold counter and registered mode outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= '0;
      btn_prev     <= 1'b0;
      mode         <= 2'd0;
      mode_changed <= 1'b0;
    end else begin
      state        <= state_n;
      hold         <= hold_n;
      btn_prev     <= btn_level;
      mode         <= mode_n;
      mode_changed <= changed_n;
    end
  end

  // Next-state logic: a release before the long threshold advances the mode,
  // reaching the threshold while held forces mode 0 and the release is ignored
  always_comb begin
    state_n = state;
    hold_n  = hold;
    mode_n  = mode;
    case (state)
      IDLE: begin
        if (btn_level && !btn_prev) begin
          state_n = PRESSED;
          hold_n  = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
          state_n = IDLE;
          mode_n  = (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;
        end else if (hold == HOLD_PRE) begin
          state_n = LONG_HELD;
          hold_n  = HOLD_LAST;
          mode_n  = 2'd0;
        end else begin
          hold_n = hold + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    changed_n = (mode_n != mode);
  end

endmodule

// File: tb/tb_mode_select.sv
// tb/tb_mode_select.sv - scoreboard bench for mode_select against a window-based reference model
module tb_mode_select;

  localparam int DB = 4;
  localparam int LP = 20;
  localparam int NM = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic [1:0] mode;
  logic       mode_changed;
  logic       btn_level;

  mode_select #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_PRESS_CYCLES(LP),
    .NUM_MODES(NM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .mode(mode),
    .mode_changed(mode_changed),
    .btn_level(btn_level)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         c;
    logic [1:0] m;
  } pulse_t;

  pulse_t exp_q[$];
  int     vectors    = 0;
  int     miscompares = 0;

  // Reference model state
  int   cyc = 0;
  bit   started = 0;
  bit   hist[$];
  bit   m_lvl;
  int   m_mode;
  bit   active;
  bit   long_done;
  int   rise_cyc;
  int   short_due;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
    m_lvl     = 1'b0;
    m_mode    = 0;
    active    = 1'b0;
    long_done = 1'b0;
    rise_cyc  = 0;
    short_due = -1;
  endtask

  task automatic expect_pulse(int new_mode);
    pulse_t p;
    p.c = cyc;
    p.m = 2'(new_mode);
    exp_q.push_back(p);
  endtask

  // Model: a level flips once the last DB synchronised samples all disagree with it;
  // presses are classified from the level timeline
  always @(posedge clk) begin
    bit all_diff;
    int nm;
    cyc++;
    if (rst) begin
      model_reset();
      started = 1'b1;
    end else if (started) begin
      if (short_due == cyc) begin
        nm = (m_mode + 1) % NM;
        if (nm != m_mode) expect_pulse(nm);
        m_mode    = nm;
        short_due = -1;
      end
      if (active && !long_done && cyc == rise_cyc + LP) begin
        long_done = 1'b1;
        if (m_mode != 0) expect_pulse(0);
        m_mode = 0;
      end
      hist.push_back(btn_in);
      void'(hist.pop_front());
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++)
        if (hist[hist.size() - 3 - k] == m_lvl) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl = !m_lvl;
        if (m_lvl) begin
          rise_cyc  = cyc;
          active    = 1'b1;
          long_done = 1'b0;
        end else begin
          if (active && !long_done) short_due = cyc + 1;
          active = 1'b0;
        end
      end
    end
  end

  // Monitor: compare outputs each cycle; a pulse pops the scoreboard
  always @(negedge clk) begin
    bit     exp_p;
    pulse_t p;
    if (started) begin
      exp_p = (exp_q.size() > 0) && (exp_q[0].c == cyc);
      vectors++;
      if (btn_level !== m_lvl) begin
        miscompares++;
        $display("FAIL btn_level cyc=%0d got=%b want=%b", cyc, btn_level, m_lvl);
      end
      vectors++;
      if (mode !== 2'(m_mode)) begin
        miscompares++;
        $display("FAIL mode cyc=%0d got=%0d want=%0d", cyc, mode, m_mode);
      end
      vectors++;
      if (mode_changed !== exp_p) begin
        miscompares++;
        $display("FAIL mode_changed cyc=%0d got=%b want=%b", cyc, mode_changed, exp_p);
      end
      if (exp_p) begin
        p = exp_q.pop_front();
        vectors++;
        if (mode !== p.m) begin
          miscompares++;
          $display("FAIL pulse_mode cyc=%0d got=%0d want=%0d", cyc, mode, p.m);
        end
      end
    end
  end

  task automatic drive(bit lvl, int n);
    btn_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic short_press();
    drive(1'b1, 10);
    drive(1'b0, 15);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 50);
    // glitch rejection
    drive(1'b1, 3);
    drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 1);
    drive(1'b0, 15);
    // three short presses: 0->1->2->0
    repeat (3) short_press();
    // reach mode 2, long press, then short press
    repeat (2) short_press();
    drive(1'b1, 40);
    drive(1'b0, 15);
    short_press();
    // back to 0, long press at mode 0
    repeat (2) short_press();
    drive(1'b1, 40);
    drive(1'b0, 15);
    // reset mid-press
    short_press();
    btn_in = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 12);
    drive(1'b0, 15);
    // randomized segments with occasional reset
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)));
    end
    drive(1'b0, 30);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_pulses got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
